// File: rtl/dmem_bridge_if.sv
// dmem_bridge_if
//   Bundles the core-side request/response signals and the 8-byte memory
//   bus signals of dmem_bridge. Clock and reset stay plain ports on the
//   modules that use this interface.
//
//   Core side : req_valid/req_ready, req_wr, req_size, req_addr, req_wdata,
//               resp_valid, resp_rdata, resp_err, stall
//   Bus side  : bus_req_valid/bus_req_ready, bus_addr, bus_wr, bus_wmask,
//               bus_wdata, bus_resp_valid, bus_rdata
//
//   modport master : the bridge (accepts core requests, masters the bus)
//   modport slave  : the surroundings (core pipeline plus memory)
interface dmem_bridge_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [1:0]  req_size;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        stall;

    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [63:0] bus_addr;
    logic        bus_wr;
    logic [7:0]  bus_wmask;
    logic [63:0] bus_wdata;
    logic        bus_resp_valid;
    logic [63:0] bus_rdata;

    modport master (
        input  req_valid, req_wr, req_size, req_addr, req_wdata,
        input  bus_req_ready, bus_resp_valid, bus_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, stall,
        output bus_req_valid, bus_addr, bus_wr, bus_wmask, bus_wdata
    );

    modport slave (
        output req_valid, req_wr, req_size, req_addr, req_wdata,
        output bus_req_ready, bus_resp_valid, bus_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, stall,
        input  bus_req_valid, bus_addr, bus_wr, bus_wmask, bus_wdata
    );
endinterface

// File: rtl/dmem_bridge.sv
// dmem_bridge
//   Turns a single-cycle MEM-stage load/store into a registered valid/ready
//   transaction on an 8-byte-aligned memory bus. Generates byte-lane masks
//   and lane-shifted store data, holds the pipeline with stall until the
//   access completes, and returns right-justified, size-masked (not
//   extended) load data. A WAIT-state counter turns a missing bus response
//   into an error response after TIMEOUT_CYC cycles.
//
//   Parameters : TIMEOUT_CYC (2..65535, default 256)
//   Ports      : clock, reset (synchronous, active-low), bif (master modport
//                of dmem_bridge_if carrying core and bus signals)
//   Option     : define DMEM_BRIDGE_ALIGN_CHECK_EN to reject misaligned
//                requests with an immediate error response instead of
//                issuing them on the bus.
module dmem_bridge #(
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic           clock,
    input  logic           reset,
    dmem_bridge_if.master  bif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    state_t      state_q, state_d;
    logic [60:0] addr_q,  addr_d;
    logic [2:0]  off_q,   off_d;
    logic [1:0]  size_q,  size_d;
    logic        wr_q,    wr_d;
    logic [7:0]  wmask_q, wmask_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q,   err_d;
    logic [15:0] cnt_q,   cnt_d;

    logic [7:0]  lane_mask;
    logic [63:0] size_mask;
`ifdef DMEM_BRIDGE_ALIGN_CHECK_EN
    logic [2:0]  align_mask;
    logic        misaligned;
`endif

    // Byte-lane pattern of the incoming request, before the offset shift
    always_comb begin
        lane_mask = 8'h01;
        case (bif.req_size)
            2'b00:   lane_mask = 8'h01;
            2'b01:   lane_mask = 8'h03;
            2'b10:   lane_mask = 8'h0F;
            default: lane_mask = 8'hFF;
        endcase
    end

    // Load-data mask of the latched request
    always_comb begin
        size_mask = 64'h0000_0000_0000_00FF;
        case (size_q)
            2'b00:   size_mask = 64'h0000_0000_0000_00FF;
            2'b01:   size_mask = 64'h0000_0000_0000_FFFF;
            2'b10:   size_mask = 64'h0000_0000_FFFF_FFFF;
            default: size_mask = '1;
        endcase
    end

`ifdef DMEM_BRIDGE_ALIGN_CHECK_EN
    always_comb begin
        align_mask = 3'b000;
        case (bif.req_size)
            2'b00:   align_mask = 3'b000;
            2'b01:   align_mask = 3'b001;
            2'b10:   align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
        misaligned = (bif.req_addr[2:0] & align_mask) != 3'b000;
    end
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        off_d   = off_q;
        size_d  = size_q;
        wr_d    = wr_q;
        wmask_d = wmask_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (bif.req_valid) begin
                    addr_d  = bif.req_addr[63:3];
                    off_d   = bif.req_addr[2:0];
                    size_d  = bif.req_size;
                    wr_d    = bif.req_wr;
                    // Lanes beyond byte 7 of a misaligned access are dropped
                    wmask_d = lane_mask << bif.req_addr[2:0];
                    wdata_d = bif.req_wdata << {bif.req_addr[2:0], 3'b000};
                    rdata_d = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
`ifdef DMEM_BRIDGE_ALIGN_CHECK_EN
                    if (misaligned) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_REQ;
                    end
`else
                    state_d = ST_REQ;
`endif
                end
            end
            ST_REQ: begin
                if (bif.bus_req_ready) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A real response wins over a timeout in the same cycle
                if (bif.bus_resp_valid) begin
                    rdata_d = wr_q ? '0
                                   : (bif.bus_rdata >> {off_q, 3'b000}) & size_mask;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == TO_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            off_q   <= '0;
            size_q  <= '0;
            wr_q    <= 1'b0;
            wmask_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            off_q   <= off_d;
            size_q  <= size_d;
            wr_q    <= wr_d;
            wmask_q <= wmask_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are forced low while reset is asserted, before the synchronous
    // reset has reached the state register.
    assign bif.req_ready     = reset && (state_q == ST_IDLE);
    assign bif.stall         = reset && (state_q != ST_IDLE);
    assign bif.bus_req_valid = reset && (state_q == ST_REQ);
    assign bif.resp_valid    = reset && (state_q == ST_RESP);
    assign bif.resp_rdata    = (reset && (state_q == ST_RESP)) ? rdata_q : '0;
    assign bif.resp_err      = reset && (state_q == ST_RESP) && err_q;
    assign bif.bus_addr      = reset ? {addr_q, 3'b000} : '0;
    assign bif.bus_wr        = reset && wr_q;
    assign bif.bus_wmask     = reset ? wmask_q : '0;
    assign bif.bus_wdata     = reset ? wdata_q : '0;

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge
//   Directed bench for dmem_bridge (TIMEOUT_CYC = 8). Expected responses are
//   queued when a request is driven and compared when resp_valid appears.
//   Honors DMEM_BRIDGE_ALIGN_CHECK_EN for the misaligned-access step.
module tb_dmem_bridge;

    logic clock = 1'b0;
    logic reset = 1'b0;

    dmem_bridge_if bif();

    dmem_bridge #(.TIMEOUT_CYC(8)) dut (
        .clock (clock),
        .reset (reset),
        .bif   (bif)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   n_start = 0;

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [63:0] rdata, input logic err, input int lat);
        exp_t e;
        e.rdata = rdata;
        e.err   = err;
        e.lat   = lat;
        sb.push_back(e);
    endtask

    task automatic drive_req(input logic wr, input logic [1:0] size,
                             input logic [63:0] addr, input logic [63:0] wdata);
        bif.req_valid = 1'b1;
        bif.req_wr    = wr;
        bif.req_size  = size;
        bif.req_addr  = addr;
        bif.req_wdata = wdata;
        n_start       = cyc;
    endtask

    // Waits up to bound cycles for resp_valid, then checks it against the
    // oldest queued expectation and confirms the return to IDLE.
    task automatic wait_resp(input string tag, input int unsigned bound);
        exp_t e;
        int unsigned k = 0;
        while (!bif.resp_valid && k < bound) begin
            step();
            k++;
        end
        chk({tag, " resp_valid"}, bif.resp_valid, 1'b1);
        if (bif.resp_valid) begin
            chk({tag, " sb_nonempty"}, 64'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk({tag, " resp_rdata"}, bif.resp_rdata, e.rdata);
                chk({tag, " resp_err"}, bif.resp_err, e.err);
                chk({tag, " latency"}, 64'(cyc - n_start), 64'(e.lat));
                chk({tag, " stall_in_resp"}, bif.stall, 1'b1);
            end
            step();
            chk({tag, " resp_one_cycle"}, bif.resp_valid, 1'b0);
            chk({tag, " idle_ready"}, bif.req_ready, 1'b1);
            chk({tag, " idle_stall"}, bif.stall, 1'b0);
        end
    endtask

    task automatic do_access(input string tag, input logic wr, input logic [1:0] size,
                             input logic [63:0] addr, input logic [63:0] wdata,
                             input int unsigned hold, input logic [63:0] rdata,
                             input logic [63:0] exp_addr, input logic [7:0] exp_mask,
                             input logic [63:0] exp_wdata, input logic [63:0] exp_rdata);
        chk({tag, " req_ready"}, bif.req_ready, 1'b1);
        chk({tag, " stall_idle"}, bif.stall, 1'b0);
        drive_req(wr, size, addr, wdata);
        push_exp(exp_rdata, 1'b0, 3 + int'(hold));
        bif.bus_req_ready = (hold == 0);
        step();
        bif.req_valid = 1'b0;
        chk({tag, " bus_req_valid"}, bif.bus_req_valid, 1'b1);
        chk({tag, " bus_addr"}, bif.bus_addr, exp_addr);
        chk({tag, " bus_wmask"}, bif.bus_wmask, exp_mask);
        chk({tag, " bus_wdata"}, bif.bus_wdata, exp_wdata);
        chk({tag, " bus_wr"}, bif.bus_wr, wr);
        chk({tag, " stall_req"}, bif.stall, 1'b1);
        for (int unsigned i = 0; i < hold; i++) begin
            step();
            chk({tag, " hold_valid"}, bif.bus_req_valid, 1'b1);
            chk({tag, " hold_addr"}, bif.bus_addr, exp_addr);
            chk({tag, " hold_wmask"}, bif.bus_wmask, exp_mask);
            chk({tag, " hold_wdata"}, bif.bus_wdata, exp_wdata);
            bif.bus_req_ready = (i == hold - 1);
        end
        step();
        bif.bus_req_ready  = 1'b0;
        chk({tag, " wait_no_valid"}, bif.bus_req_valid, 1'b0);
        chk({tag, " stall_wait"}, bif.stall, 1'b1);
        bif.bus_resp_valid = 1'b1;
        bif.bus_rdata      = rdata;
        step();
        bif.bus_resp_valid = 1'b0;
        bif.bus_rdata      = '0;
        wait_resp(tag, 4);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bif.req_valid      = 1'b0;
        bif.req_wr         = 1'b0;
        bif.req_size       = 2'b00;
        bif.req_addr       = '0;
        bif.req_wdata      = '0;
        bif.bus_req_ready  = 1'b0;
        bif.bus_resp_valid = 1'b0;
        bif.bus_rdata      = '0;

        // Reset state
        #1;
        chk("rst req_ready", bif.req_ready, 1'b0);
        chk("rst stall", bif.stall, 1'b0);
        step();
        step();
        chk("rst req_ready2", bif.req_ready, 1'b0);
        chk("rst bus_req_valid", bif.bus_req_valid, 1'b0);
        chk("rst resp_valid", bif.resp_valid, 1'b0);
        chk("rst bus_wmask", bif.bus_wmask, 8'h00);
        reset = 1'b1;
        step();
        chk("post_rst req_ready", bif.req_ready, 1'b1);

        // Load D, immediate ready and response
        do_access("ld_d", 1'b0, 2'b11, 64'h0000_0000_8000_0000, '0, 0,
                  64'h1122_3344_5566_7788, 64'h0000_0000_8000_0000, 8'hFF,
                  64'h0, 64'h1122_3344_5566_7788);

        // Store B at offset 5
        do_access("st_b", 1'b1, 2'b00, 64'h0000_0000_8000_0005, 64'h0000_0000_0000_00AB, 0,
                  64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_8000_0000, 8'h20,
                  64'h0000_AB00_0000_0000, 64'h0);

        // Load H at offset 6 with 4 cycles of bus back-pressure
        do_access("ld_h", 1'b0, 2'b01, 64'h0000_0000_8000_0006, '0, 4,
                  64'hBEEF_0000_0000_0000, 64'h0000_0000_8000_0000, 8'hC0,
                  64'h0, 64'h0000_0000_0000_BEEF);

        // Timeout: no bus response, error 8 cycles after WAIT entry
        drive_req(1'b0, 2'b10, 64'h0000_0000_8000_0010, '0);
        push_exp(64'h0, 1'b1, 10);
        bif.bus_req_ready = 1'b1;
        step();
        bif.req_valid = 1'b0;
        step();
        bif.bus_req_ready = 1'b0;
        chk("to wait_stall", bif.stall, 1'b1);
        for (int i = 0; i < 7; i++) begin
            step();
            chk("to no_early_resp", bif.resp_valid, 1'b0);
        end
        wait_resp("to", 4);
        // Late response while idle must be ignored
        bif.bus_resp_valid = 1'b1;
        bif.bus_rdata      = 64'hDEAD_BEEF_DEAD_BEEF;
        step();
        bif.bus_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stale resp_valid", bif.resp_valid, 1'b0);
            chk("stale req_ready", bif.req_ready, 1'b1);
            step();
        end

        // Misaligned W store at offset 2
`ifdef DMEM_BRIDGE_ALIGN_CHECK_EN
        drive_req(1'b1, 2'b10, 64'h0000_0000_8000_0002, 64'h0000_0000_DEAD_BEEF);
        push_exp(64'h0, 1'b1, 1);
        step();
        bif.req_valid = 1'b0;
        chk("mis bus_req_valid", bif.bus_req_valid, 1'b0);
        wait_resp("mis", 0);
`else
        do_access("mis", 1'b1, 2'b10, 64'h0000_0000_8000_0002, 64'h0000_0000_DEAD_BEEF, 0,
                  64'h0, 64'h0000_0000_8000_0000, 8'h3C,
                  64'h0000_DEAD_BEEF_0000, 64'h0);
`endif

        // Misaligned-free sanity: load W at offset 4
        do_access("ld_w", 1'b0, 2'b10, 64'h0000_0000_8000_0024, '0, 1,
                  64'h1122_3344_5566_7788, 64'h0000_0000_8000_0020, 8'hF0,
                  64'h0, 64'h0000_0000_1122_3344);

        // Reset while in WAIT
        drive_req(1'b0, 2'b11, 64'h0000_0000_8000_0040, '0);
        bif.bus_req_ready = 1'b1;
        step();
        bif.req_valid = 1'b0;
        step();
        bif.bus_req_ready = 1'b0;
        chk("rw in_wait", bif.stall, 1'b1);
        reset = 1'b0;
        #1;
        chk("rw req_ready", bif.req_ready, 1'b0);
        chk("rw stall", bif.stall, 1'b0);
        chk("rw bus_req_valid", bif.bus_req_valid, 1'b0);
        chk("rw resp_valid", bif.resp_valid, 1'b0);
        chk("rw bus_addr", bif.bus_addr, 64'h0);
        chk("rw bus_wmask", bif.bus_wmask, 8'h00);
        chk("rw bus_wr", bif.bus_wr, 1'b0);
        bif.bus_resp_valid = 1'b1;
        bif.bus_rdata      = 64'h0123_4567_89AB_CDEF;
        step();
        step();
        reset = 1'b1;
        #1;
        chk("rw release_ready", bif.req_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rw no_resp", bif.resp_valid, 1'b0);
            chk("rw idle_ready", bif.req_ready, 1'b1);
        end
        bif.bus_resp_valid = 1'b0;

        chk("sb drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Data-memory bridge that sits directly downstream of the core's MEM-stage memory port. It turns a single-cycle load/store request into a registered valid/ready transaction on an 8-byte-aligned memory bus. It generates byte lanes and write masks, holds the pipeline with `stall` until the access completes, and returns right-justified load data that has not been sign- or zero-extended. Extension remains in the MEM stage.

## Interface
- `TIMEOUT_CYC`, default 256: maximum cycles spent in WAIT before an error response is returned. Legal range is 2..65535.
- `clock  in  1`: clock.
- `reset  in  1`: reset, synchronous, active-low.
- `req_valid  in  1`: core request (mem_ena).
- `req_ready  out  1`: bridge can accept a request.
- `req_wr  in  1`: 1 = store, 0 = load.
- `req_size  in  2`: access size. 00 = B, 01 = H, 10 = W, 11 = D.
- `req_addr  in  64`: byte address.
- `req_wdata  in  64`: store data, low-justified.
- `resp_valid  out  1`: one-cycle completion pulse.
- `resp_rdata  out  64`: load data, right-justified and masked to size. It is 0 for stores.
- `resp_err  out  1`: error status, valid with `resp_valid`.
- `stall  out  1`: request in flight.
- `bus_req_valid  out  1`, `bus_req_ready  in  1`: bus request handshake.
- `bus_addr  out  64`: `{req_addr[63:3], 3'b000}`.
- `bus_wr  out  1`: bus write.
- `bus_wmask  out  8`: byte-lane mask.
- `bus_wdata  out  64`: lane-shifted store data.
- `bus_resp_valid  in  1`, `bus_rdata  in  64`: bus response.

## Operation
- The FSM has four states.
  - **IDLE**: `req_ready=1`. On `req_valid` it latches addr, size, wr, wdata and offset `off=addr[2:0]`, then moves to REQ.
  - **REQ**: `bus_req_valid=1`. All bus outputs are held stable until `bus_req_ready`, then the FSM moves to WAIT.
  - **WAIT**: waits for `bus_resp_valid`. It captures `(bus_rdata >> 8*off) & sizemask` and moves to RESP. A 16-bit counter starts at 0 on entry and increments each cycle. When it reaches `TIMEOUT_CYC-1` without a response, the FSM goes to RESP with error set.
  - **RESP**: `resp_valid=1` for exactly one cycle, then IDLE.
- Masks, shifted left by `off`:
  - B = 0x01, H = 0x03, W = 0x0F, D = 0xFF.
  - `bus_wmask` is the result truncated to 8 bits.
  - For loads the mask is still driven, but it is informational only.
- `bus_wdata = req_wdata << 8*off`, truncated to 64 bits.
- `sizemask`: B = 0xFF, H = 0xFFFF, W = 0xFFFF_FFFF, D = all ones.
- Stores also wait for `bus_resp_valid`, which acts as the write acknowledge. `bus_rdata` is ignored for stores and `resp_rdata=0`.
- `stall = (state != IDLE)`. The MEM stage freezes while `stall=1`.
- `bus_resp_valid` is ignored in IDLE, REQ and RESP. A stale response therefore never completes a new request.

## Timing
- **Reset values**: while `reset=0`, the state is IDLE and every output is 0, including `req_ready`. In the first cycle after reset releases, `req_ready=1`.
- **Minimum latency**: with the request accepted at cycle N:
  - `bus_req_valid` is high at N+1.
  - If `bus_req_ready` is high at N+1, the FSM is in WAIT at N+2.
  - A response at N+2 gives `resp_valid` at N+3.
  - The core therefore sees a 3-cycle minimum.
- **Back-to-back**: the next request is accepted no earlier than the cycle after RESP. There is no overlap.
- **Bus handshake**: `bus_req_valid` never deasserts before `bus_req_ready`. The bus must not assert `bus_resp_valid` in the same cycle as the request handshake; such a response is lost and is recovered by the timeout.
- **Timeout**: `resp_valid` rises with `resp_err=1` and `resp_rdata=0`, exactly `TIMEOUT_CYC` cycles after entering WAIT.
- **Reset mid-operation**: from any state the FSM returns to IDLE in the next cycle. No `resp_valid` is produced for the aborted request.

## Configuration
- **`DMEM_BRIDGE_ALIGN_CHECK_EN` defined**: a request with `addr % size != 0` is never sent to the bus. The FSM goes IDLE→RESP directly, giving `resp_valid` with `resp_err=1` and `resp_rdata=0` at N+1, with `bus_req_valid` held at 0.
- **`DMEM_BRIDGE_ALIGN_CHECK_EN` undefined**: misaligned requests are issued normally, using the truncated mask and shift. Only the upper lanes that fit inside the 8-byte word are accessed, and `resp_err` comes only from timeout.

## Test plan
- **Load D**: addr 0x8000_0000, bus ready and respond immediately with 0x1122334455667788 → `bus_wmask` 0xFF, `resp_rdata` 0x1122334455667788, `resp_valid` at N+3, `stall` high for N+1..N+3.
- **Store B**: addr 0x8000_0005, wdata 0xAB → `bus_addr` 0x8000_0000, `bus_wmask` 0x20, `bus_wdata` 0x0000_AB00_0000_0000; `resp_rdata` 0.
- **Load H**: addr 0x…6, `bus_rdata` 0xBEEF_0000_0000_0000 → `resp_rdata` 0xBEEF. Add 4 cycles of `bus_req_ready=0` → the bus outputs stay constant and `resp_valid` is at N+7.
- **Timeout**: `TIMEOUT_CYC`=8, no response → `resp_err=1` 8 cycles after WAIT entry. A late `bus_resp_valid` in IDLE causes no response.
- **Misaligned W** at addr 0x…2:
  - With the macro: `resp_err=1` at N+1 and no `bus_req_valid`.
  - Without the macro: `bus_wmask` 0x3C.
- **Reset in WAIT**: the FSM returns to IDLE, all outputs are 0 during reset, `req_ready=1` the cycle after release, and no `resp_valid` is produced.
